// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: issues register-file reads, resolves write-back hazards by forwarding,
// and hands operands to execute over a valid/ready interface. Also drives the regfile write port.
module operand_fetch_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] AR_1,
    output logic [ADDR_W-1:0] AR_2,
    output logic              RD,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    output logic              WR,
    output logic [ADDR_W-1:0] AW,
    output logic [DATA_W-1:0] WD3,
    output logic              EN,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_we
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t state_q, state_d;

    logic              accept;
    logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [ADDR_W-1:0] ar1_q, ar1_d, ar2_q, ar2_d, out_rd_q, out_rd_d;
    logic              we_q, we_d, out_we_q, out_we_d, out_valid_q, out_valid_d;
    logic              fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic [DATA_W-1:0] fwd_data1_q, fwd_data1_d, fwd_data2_q, fwd_data2_d;
    logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [DATA_W-1:0] op1, op2;

    function automatic logic is_zero(input logic [ADDR_W-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    function automatic logic wb_hit(input logic we, input logic [ADDR_W-1:0] wa,
                                    input logic [ADDR_W-1:0] r);
        return we && (wa == r) && !is_zero(r);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = HOLD;
            HOLD:    if (out_ready) state_d = accept ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        accept   = in_valid && in_ready && !rst;
        RD       = accept;
        AR_1     = accept ? in_rs1 : ar1_q;
        AR_2     = accept ? in_rs2 : ar2_q;
    end

    // Regfile returns pre-write data on a same-edge read, so the newest value wins in priority order
    always_comb begin
        op1 = is_zero(rs1_q) ? '0 :
              wb_hit(wb_we, wb_addr, rs1_q) ? wb_data :
              fwd1_q ? fwd_data1_q : RD1;
        op2 = is_zero(rs2_q) ? '0 :
              wb_hit(wb_we, wb_addr, rs2_q) ? wb_data :
              fwd2_q ? fwd_data2_q : RD2;
    end

    always_comb begin
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        we_d        = we_q;
        ar1_d       = ar1_q;
        ar2_d       = ar2_q;
        fwd1_d      = fwd1_q;
        fwd2_d      = fwd2_q;
        fwd_data1_d = fwd_data1_q;
        fwd_data2_d = fwd_data2_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;
        out_valid_d = out_valid_q;

        case (state_q)
            READ: begin
                out_a_d     = op1;
                out_b_d     = op2;
                out_rd_d    = rd_q;
                out_we_d    = we_q;
                out_valid_d = 1'b1;
                fwd1_d      = 1'b0;
                fwd2_d      = 1'b0;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    if (wb_hit(wb_we, wb_addr, rs1_q)) out_a_d = wb_data;
                    if (wb_hit(wb_we, wb_addr, rs2_q)) out_b_d = wb_data;
                end
            end
            default: ;
        endcase

        if (accept) begin
            rs1_d       = in_rs1;
            rs2_d       = in_rs2;
            rd_d        = in_rd;
            we_d        = in_we;
            ar1_d       = in_rs1;
            ar2_d       = in_rs2;
            fwd1_d      = wb_hit(wb_we, wb_addr, in_rs1);
            fwd2_d      = wb_hit(wb_we, wb_addr, in_rs2);
            fwd_data1_d = wb_data;
            fwd_data2_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            ar1_q       <= '0;
            ar2_q       <= '0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd_data1_q <= '0;
            fwd_data2_q <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            ar1_q       <= ar1_d;
            ar2_q       <= ar2_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            fwd_data1_q <= fwd_data1_d;
            fwd_data2_q <= fwd_data2_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_rd_q    <= out_rd_d;
            out_we_q    <= out_we_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;
    assign out_we    = out_we_q;

    assign WR  = wb_we & ~rst;
    assign AW  = wb_addr;
    assign WD3 = wb_data;
    assign EN  = ~rst;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: a behavioural register file on the regfile ports, an architectural
// register model fed from write-back stimulus, and a scoreboard of accepted requests.
module tb_operand_fetch_stage;

    localparam int DW = 32;
    localparam int AWID = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_we, wb_we, RD, WR, EN, out_valid, out_ready, out_we;
    logic [AWID-1:0] in_rs1, in_rs2, in_rd, wb_addr, AR_1, AR_2, AW, out_rd;
    logic [DW-1:0]   wb_data, RD1, RD2, WD3, out_a, out_b;

    always #5 clk = ~clk;

    operand_fetch_stage #(.DATA_W(DW), .ADDR_W(AWID), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .AR_1(AR_1), .AR_2(AR_2), .RD(RD), .RD1(RD1), .RD2(RD2),
        .WR(WR), .AW(AW), .WD3(WD3), .EN(EN),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_we(out_we)
    );

    // Environment register file: registered read returns pre-write data on a shared edge
    logic [DW-1:0] rf [32];
    logic [DW-1:0] rd1_q = '0, rd2_q = '0;
    always @(posedge clk) begin
        if (EN && RD) begin
            rd1_q <= rf[AR_1];
            rd2_q <= rf[AR_2];
        end
        if (EN && WR) rf[AW] <= WD3;
    end
    assign RD1 = rd1_q;
    assign RD2 = rd2_q;

    // Architectural register state, driven only by the bench's own write-back stimulus
    logic [DW-1:0] arch [32];
    always @(posedge clk) begin
        if (wb_we && !rst) arch[wb_addr] <= wb_data;
    end

    function automatic logic [DW-1:0] arch_val(input logic [AWID-1:0] r);
        return (r == '0) ? '0 : arch[r];
    endfunction

    typedef struct packed {
        logic [AWID-1:0] rs1;
        logic [AWID-1:0] rs2;
        logic [AWID-1:0] rd;
        logic            we;
        int unsigned     cyc;
    } req_t;

    req_t        q[$];
    req_t        front;
    int unsigned cyc = 0;
    bit          seen_front = 1'b0;
    int          passed = 0;
    int          total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            seen_front = 1'b0;
            check("en_in_rst", {63'd0, EN}, 64'd0);
            check("rd_in_rst", {63'd0, RD}, 64'd0);
            check("wr_in_rst", {63'd0, WR}, 64'd0);
        end else begin
            check("en", {63'd0, EN}, 64'd1);
            check("wr", {63'd0, WR}, {63'd0, wb_we});
            if (wb_we) begin
                check("aw", {59'd0, AW}, {59'd0, wb_addr});
                check("wd3", {32'd0, WD3}, {32'd0, wb_data});
            end
            check("rd_strobe", {63'd0, RD}, {63'd0, in_valid && in_ready});
            if (RD) begin
                check("ar_1", {59'd0, AR_1}, {59'd0, in_rs1});
                check("ar_2", {59'd0, AR_2}, {59'd0, in_rs2});
            end
            if (q.size() == 0) begin
                check("out_valid_empty", {63'd0, out_valid}, 64'd0);
                check("in_ready_empty", {63'd0, in_ready}, 64'd1);
            end else if (!out_valid) begin
                check("in_ready_fetching", {63'd0, in_ready}, 64'd0);
            end else begin
                front = q[0];
                if (!seen_front) begin
                    check("latency", 64'(cyc - front.cyc), 64'd2);
                    seen_front = 1'b1;
                end
                check("out_a", {32'd0, out_a}, {32'd0, arch_val(front.rs1)});
                check("out_b", {32'd0, out_b}, {32'd0, arch_val(front.rs2)});
                check("out_rd", {59'd0, out_rd}, {59'd0, front.rd});
                check("out_we", {63'd0, out_we}, {63'd0, front.we});
                check("in_ready_hold", {63'd0, in_ready}, {63'd0, out_ready});
                if (out_ready) begin
                    void'(q.pop_front());
                    seen_front = 1'b0;
                end
            end
            if (in_valid && in_ready)
                q.push_back('{rs1: in_rs1, rs2: in_rs2, rd: in_rd, we: in_we, cyc: cyc});
        end
    end

    task automatic drive(input bit iv, input logic [AWID-1:0] a, input logic [AWID-1:0] b,
                         input logic [AWID-1:0] d, input bit w, input bit wbe,
                         input logic [AWID-1:0] wa, input logic [DW-1:0] wd, input bit ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_rs1    = a;
        in_rs2    = b;
        in_rd     = d;
        in_we     = w;
        wb_we     = wbe;
        wb_addr   = wa;
        wb_data   = wd;
        out_ready = ordy;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = 0;
        wb_we = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_a", {32'd0, out_a}, 64'd0);
        check("reset_out_b", {32'd0, out_b}, 64'd0);
        check("reset_out_rd", {59'd0, out_rd}, 64'd0);
        check("reset_out_we", {63'd0, out_we}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Preload every register through the write port
        for (int unsigned r = 0; r < 32; r++) drive(0, 0, 0, 0, 0, 1, 5'(r), $urandom, 1);
        drive(0, 0, 0, 0, 0, 1, 5'd3, 32'h11, 1);
        drive(0, 0, 0, 0, 0, 1, 5'd5, 32'h22, 1);
        idle(2);

        // Plain read of preloaded registers
        drive(1, 5'd3, 5'd5, 5'd7, 1, 0, 0, 0, 1);
        idle(3);
        // Write-back in the accept cycle
        drive(1, 5'd4, 5'd1, 5'd2, 0, 1, 5'd4, 32'hAB, 1);
        idle(3);
        // Write-back in the read cycle
        drive(1, 5'd1, 5'd6, 5'd3, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 5'd6, 32'h55, 1);
        idle(3);
        // Stall with a write to a held operand, then accept on the releasing cycle
        drive(1, 5'd3, 5'd2, 5'd4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5'd3, 32'h99, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5'd8, 5'd9, 5'd1, 1, 0, 0, 0, 1);
        idle(3);
        // Register zero is never forwarded; identical sources
        drive(1, 5'd0, 5'd9, 5'd2, 1, 1, 5'd0, 32'hFF, 1);
        idle(3);
        drive(1, 5'd9, 5'd9, 5'd3, 0, 1, 5'd9, 32'h1234, 1);
        idle(3);
        // Reset while a read is in flight
        drive(1, 5'd3, 5'd5, 5'd7, 1, 0, 0, 0, 1);
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        // Randomised traffic concentrated on a few registers to provoke hazards
        for (int unsigned i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 60,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  5'($urandom), 1'($urandom),
                  $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 70);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            else rst = 1'b0;
        end
        #1 rst = 1'b0;
        idle(6);
        @(negedge clk);
        check("drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
